screen_fb_dbuf: RTL

- Parametrised, double-buffered monochrome frame buffer with VGA pixel readout; successor to the single-bank screen interface.
- Host writes packed pixel words into the back bank through a valid/ready port; can request a hardware clear of the back bank, or a bank swap that is deferred to the end of the frame (tear-free).
- Readout converts the sync generator's column/row counters (c1/c2) into an RGB pixel with fixed 2-cycle latency.

---
 rtl/screen_fb_dbuf.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/screen_fb_dbuf.sv
// Double-buffered monochrome frame buffer with VGA pixel readout.
// Ports: clk/rst, c1/c2 sync counters, wr_* host write port into the
// back bank, clr_req/clr_done bank clear, swap_req/swap_done deferred
// swap, front_bank (displayed bank), rgb pixel (2-cycle latency).
module screen_fb_dbuf #(
    parameter int                IMG_W   = 128,
    parameter int                IMG_H   = 128,
    parameter int                WORD_W  = 8,
    parameter int                AW      = 11,
    parameter int                X_START = 144,
    parameter int                Y_START = 35,
    parameter int                H_TOTAL = 800,
    parameter int                V_TOTAL = 525,
    parameter int                RGB_W   = 3,
    parameter logic [RGB_W-1:0]  FG_RGB  = 3'b111,
    parameter logic [RGB_W-1:0]  BG_RGB  = 3'b000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       c1,
    input  logic [10:0]       c2,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              clr_done,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              front_bank,
    output logic [RGB_W-1:0]  rgb
);

    localparam int DEPTH = IMG_W * IMG_H / WORD_W;
    localparam int XW    = $clog2(IMG_W);
    localparam int IW    = $clog2(WORD_W);
    localparam int BW    = AW + IW;
    localparam int YW    = BW - XW;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SWAP_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              front_q, front_d;
    logic              clr_done_q, clr_done_d;
    logic              swap_done_q, swap_done_d;

    logic              inwin_q, inwin_d;
    logic [IW-1:0]     index_q, index_d;
    logic [WORD_W-1:0] rd_word_q;
    logic [RGB_W-1:0]  rgb_q, rgb_d;

    // Both banks share one array; the MSB of the index selects the bank.
    logic [WORD_W-1:0] mem [2*DEPTH];

    logic              we;
    logic [AW-1:0]     waddr;
    logic [WORD_W-1:0] wdata;
    logic [AW-1:0]     rd_addr;
    logic              frame_end;

    // Stage 0: window test and pixel-to-word mapping.
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [BW-1:0]     bit_idx;
    int                c1_i, c2_i;

    always_comb begin
        c1_i    = int'(c1);
        c2_i    = int'(c2);
        inwin_d = (c1_i >= X_START) && (c1_i < X_START + IMG_W) &&
                  (c2_i >= Y_START) && (c2_i < Y_START + IMG_H);
        x       = XW'(c1 - 11'(X_START));
        y       = YW'(c2 - 11'(Y_START));
        // IMG_W is a power of two, so y*IMG_W + x is a concatenation.
        bit_idx = {y, x};
        rd_addr = inwin_d ? bit_idx[BW-1:IW] : '0;
        // MSB of the word is the leftmost pixel.
        index_d = IW'(WORD_W - 1) - bit_idx[IW-1:0];
    end

    assign frame_end = (c1 == 11'(H_TOTAL - 1)) && (c2 == 11'(V_TOTAL - 1));

    // Write mux: the clear engine owns the back bank while clearing.
    always_comb begin
        we    = 1'b0;
        waddr = wr_addr;
        wdata = wr_data;
        if (state_q == CLEAR) begin
            we    = 1'b1;
            waddr = cnt_q;
            wdata = '0;
        end else if (state_q == IDLE && wr_valid) begin
            we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{~front_q, waddr}] <= wdata;
        end
        rd_word_q <= mem[{front_q, rd_addr}];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        front_d     = front_q;
        clr_done_d  = 1'b0;
        swap_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (swap_req) begin
                    state_d = SWAP_WAIT;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            SWAP_WAIT: begin
                // Frame end lies in blanking, so the flip never tears.
                if (frame_end) begin
                    front_d     = ~front_q;
                    swap_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rgb_d = '0;
        if (inwin_q) begin
            rgb_d = rd_word_q[index_q] ? FG_RGB : BG_RGB;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            front_q     <= 1'b0;
            clr_done_q  <= 1'b0;
            swap_done_q <= 1'b0;
            inwin_q     <= 1'b0;
            index_q     <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            front_q     <= front_d;
            clr_done_q  <= clr_done_d;
            swap_done_q <= swap_done_d;
            inwin_q     <= inwin_d;
            index_q     <= index_d;
            rgb_q       <= rgb_d;
        end
    end

    assign wr_ready   = (state_q == IDLE);
    assign clr_done   = clr_done_q;
    assign swap_done  = swap_done_q;
    assign front_bank = front_q;
    assign rgb        = rgb_q;

endmodule
